// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master controller: state encoding,
// the address of the attached target and transaction sizing constants.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WRITE,
    ST_WACK,
    ST_READ,
    ST_MACK,
    ST_STOP
  } state_t;

  localparam logic [6:0] SLAVE_ADDR = 7'b0101010;
  localparam int         BYTES      = 4;
  localparam int         FULL_SLOTS = 47;
  localparam int         NACK_SLOTS = 11;

endpackage

// File: rtl/i2c_clk_gen.sv
// Quarter-period timing base: a tick every DIV clocks and a 2-bit phase
// that walks Q0..Q3 inside each bit slot. Restart realigns both to zero.
module i2c_clk_gen #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  output logic       tick,
  output logic [1:0] phase
);

  logic [7:0] div_cnt;

  assign tick = (div_cnt == 8'(DIV - 1));

  // Divider and phase counter; restart aligns a new transaction to Q0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= '0;
    end else if (restart) begin
      div_cnt <= '0;
      phase   <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      phase   <= phase + 2'd1;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/i2c_master_controller.sv
// Single-transaction I2C master: START, 7-bit address + R/W, four data
// bytes (write or read), STOP. Bus lines are open-drain, pulled low only.
module i2c_master_controller
  import i2c_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  output logic        ready,
  input  logic [6:0]  addr,
  input  logic        rw,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        nack,
  inout  wire         sda,
  inout  wire         scl
);

  state_t      state;
  state_t      next_state;
  logic        tick;
  logic [1:0]  phase;
  logic        accept;
  logic        slot_end;
  logic        sample_edge;
  logic        last_byte;
  logic        slot_scl_low;
  logic [7:0]  addr_byte;
  logic [31:0] tx_word;
  logic [31:0] rx_word;
  logic [2:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic        sda_low;
  logic        scl_low;

  assign ready        = (state == ST_IDLE);
  assign accept       = ready && req;
  assign slot_end     = tick && (phase == 2'd3);
  assign sample_edge  = tick && (phase == 2'd2);
  assign last_byte    = (byte_cnt == 2'(BYTES - 1));
  assign slot_scl_low = (phase == 2'd0) || (phase == 2'd3);

  assign sda = sda_low ? 1'b0 : 1'bz;
  assign scl = scl_low ? 1'b0 : 1'bz;

  i2c_clk_gen #(
    .DIV(DIV)
  ) u_clk_gen (
    .clk    (clk),
    .rst    (rst),
    .restart(accept),
    .tick   (tick),
    .phase  (phase)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: every move other than IDLE->START happens at a slot boundary
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (req) next_state = ST_START;
      ST_START:    if (slot_end) next_state = ST_ADDR;
      ST_ADDR:     if (slot_end && bit_cnt == 3'd0) next_state = ST_ADDR_ACK;
      ST_ADDR_ACK: if (slot_end) next_state = nack ? ST_STOP : (addr_byte[0] ? ST_READ : ST_WRITE);
      ST_WRITE:    if (slot_end && bit_cnt == 3'd0) next_state = ST_WACK;
      ST_WACK:     if (slot_end) next_state = last_byte ? ST_STOP : ST_WRITE;
      ST_READ:     if (slot_end && bit_cnt == 3'd0) next_state = ST_MACK;
      ST_MACK:     if (slot_end) next_state = last_byte ? ST_STOP : ST_READ;
      ST_STOP:     if (slot_end) next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Bus drive: SCL low in Q0/Q3 of data slots, SDA only changes in Q0
  always_comb begin
    sda_low = 1'b0;
    scl_low = 1'b0;
    case (state)
      ST_START: begin
        scl_low = (phase == 2'd3);
        sda_low = (phase != 2'd0);
      end
      ST_ADDR: begin
        scl_low = slot_scl_low;
        sda_low = ~addr_byte[bit_cnt];
      end
      ST_WRITE: begin
        scl_low = slot_scl_low;
        sda_low = ~tx_word[31];
      end
      ST_ADDR_ACK, ST_WACK, ST_READ: begin
        scl_low = slot_scl_low;
      end
      ST_MACK: begin
        scl_low = slot_scl_low;
        sda_low = ~last_byte;
      end
      ST_STOP: begin
        scl_low = (phase == 2'd0);
        sda_low = (phase != 2'd3);
      end
      default: begin
        sda_low = 1'b0;
        scl_low = 1'b0;
      end
    endcase
  end

  // Datapath: capture request, shift bits, count bytes, report completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_byte <= '0;
      tx_word   <= '0;
      rx_word   <= '0;
      rdata     <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      nack      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        addr_byte <= {addr, rw};
        tx_word   <= wdata;
        bit_cnt   <= 3'd7;
        byte_cnt  <= '0;
        nack      <= 1'b0;
      end
      if (sample_edge) begin
        if (state == ST_ADDR_ACK) nack <= sda;
        if (state == ST_READ) rx_word <= {rx_word[30:0], sda};
      end
      if (slot_end) begin
        case (state)
          ST_ADDR, ST_READ: begin
            bit_cnt <= (bit_cnt == 3'd0) ? 3'd7 : bit_cnt - 3'd1;
          end
          ST_WRITE: begin
            bit_cnt <= (bit_cnt == 3'd0) ? 3'd7 : bit_cnt - 3'd1;
            tx_word <= {tx_word[30:0], 1'b0};
          end
          ST_WACK, ST_MACK: begin
            byte_cnt <= last_byte ? 2'd0 : byte_cnt + 2'd1;
          end
          ST_STOP: begin
            done <= 1'b1;
            if (addr_byte[0] && !nack) rdata <= rx_word;
          end
          default: begin
            bit_cnt <= bit_cnt;
          end
        endcase
      end
    end
  end

endmodule
